// File: rtl/mux16_arb_pkg.sv
// Shared definitions for the 16-way round-robin mux arbiter.
// Holds the requester count, select width, FSM state type and a one-hot helper.
package mux16_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: returns the first requester at or after the pointer,
// wrapping modulo N_REQ, by rotate / priority-encode / un-rotate.
module rr_priority_pick
    import mux16_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_pick,
    output logic             o_any
);

    logic [N_REQ-1:0] w_rot;
    logic [SEL_W-1:0] w_enc;

    // Bit 0 of w_rot corresponds to requester i_ptr.
    assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = SEL_W'(i);
            end
        end
    end

    assign o_pick = w_enc + i_ptr;
    assign o_any  = |i_req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 mux, with a bounded hold time
// per grant and a one-cycle TIMEOUT pulse when a grant is forcibly revoked.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
    output logic [SEL_W-1:0] o_sel,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    arb_state_t       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [7:0]       r_hcnt;
    logic [SEL_W-1:0] r_sel;
    logic [N_REQ-1:0] r_gnt;
    logic             r_busy;
    logic             r_timeout;

    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [7:0]       w_hcnt_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic             w_busy_nxt;
    logic             w_timeout_nxt;

    logic [SEL_W-1:0] w_pick_ptr;
    logic [SEL_W-1:0] w_pick;
    logic             w_any;
    logic             w_owner_req;
    logic             w_at_max;
    logic             w_release;

    // While granting, the pick is only consumed on release, when the pointer
    // moves to owner+1; looking ahead here gives back-to-back grants.
    assign w_pick_ptr  = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;
    assign w_owner_req = i_req[r_sel];
    assign w_at_max    = (r_hcnt >= HOLD_LIM);
    assign w_release   = i_done || !w_owner_req || w_at_max;

    rr_priority_pick u_pick (
        .i_req  (i_req),
        .i_ptr  (w_pick_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_hcnt    <= '0;
            r_sel     <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_sel     <= w_sel_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hcnt_nxt    = r_hcnt;
        w_sel_nxt     = r_sel;
        w_gnt_nxt     = r_gnt;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = onehot(w_pick);
                    w_sel_nxt   = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_hcnt_nxt  = 8'd1;
                end
            end
            GRANT: begin
                if (!w_release) begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end else begin
                    w_ptr_nxt = r_sel + SEL_W'(1);
                    // DONE coinciding with the hold limit counts as a normal release.
                    w_timeout_nxt = w_at_max && w_owner_req && !i_done;
                    if (w_any) begin
                        w_gnt_nxt  = onehot(w_pick);
                        w_sel_nxt  = w_pick;
                        w_hcnt_nxt = 8'd1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                        w_hcnt_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_sel     = r_sel;
    assign o_gnt     = r_gnt;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: directed stimulus pushes hand-computed
// expected outputs; a monitor pops and compares one entry after each clock edge.
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        timeout;

    typedef struct packed {
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        busy;
        logic        to;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad = 0;

    mux16_rr_arbiter #(.MAX_HOLD(8)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_done    (done),
        .o_sel     (sel),
        .o_gnt     (gnt),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t act, input exp_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got gnt=%h sel=%0d busy=%b to=%b, want gnt=%h sel=%0d busy=%b to=%b",
                     nm, act.gnt, act.sel, act.busy, act.to, want.gnt, want.sel, want.busy, want.to);
        end
    endtask

    // Monitor: outputs are registered, so every cycle after an edge is a response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t  e;
                string n;
                e = q.pop_front();
                n = nq.pop_front();
                check(n, {gnt, sel, busy, timeout}, e);
            end
        end
    end

    task automatic step(input logic [15:0] r, input logic d, input logic [15:0] eg,
                        input logic [3:0] es, input logic eb, input logic et, input string nm);
        req  = r;
        done = d;
        q.push_back({eg, es, eb, et});
        nq.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        // Reset held with random requests.
        for (int i = 0; i < 3; i++) begin
            req = 16'($urandom);
            @(negedge clk);
            check("reset_hold", {gnt, sel, busy, timeout}, '0);
        end
        req   = '0;
        rst_n = 1'b1;

        // Single requester 5, DONE on the third grant cycle with REQ dropped.
        step(16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0, "single_g1");
        step(16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0, "single_g2");
        step(16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0, "single_g3");
        step(16'h0000, 1'b1, 16'h0000, 4'd5, 1'b0, 1'b0, "single_rel");
        step(16'h0000, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b0, "idle_hold");
        step(16'h0000, 1'b1, 16'h0000, 4'd5, 1'b0, 1'b0, "idle_done");

        // Pointer is 6: requester 8 wins; then async reset mid-grant.
        step(16'h0100, 1'b0, 16'h0100, 4'd8, 1'b1, 1'b0, "pre_reset_grant");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {gnt, sel, busy, timeout}, '0);
        req = 16'($urandom);
        @(negedge clk);
        check("reset_no_clock", {gnt, sel, busy, timeout}, '0);
        req   = '0;
        rst_n = 1'b1;

        // Full contention, DONE every cycle: grants start at 0 after reset.
        step(16'hFFFF, 1'b1, 16'h0001, 4'd0, 1'b1, 1'b0, "full_0");
        for (int i = 1; i <= 17; i++) begin
            step(16'hFFFF, 1'b1, 16'h0001 << (i % 16), 4'(i % 16), 1'b1, 1'b0, "full_rot");
        end
        step(16'h0000, 1'b1, 16'h0000, 4'd1, 1'b0, 1'b0, "full_idle");

        // Timeout rotation between requesters 3 and 9 (pointer is 2).
        step(16'h0208, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b0, "to_rot_g3");
        for (int i = 0; i < 7; i++) step(16'h0208, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b0, "to_rot_h3");
        step(16'h0208, 1'b0, 16'h0200, 4'd9, 1'b1, 1'b1, "to_rot_g9");
        for (int i = 0; i < 7; i++) step(16'h0208, 1'b0, 16'h0200, 4'd9, 1'b1, 1'b0, "to_rot_h9");
        step(16'h0208, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b1, "to_rot_back3");
        step(16'h0000, 1'b1, 16'h0000, 4'd3, 1'b0, 1'b0, "to_rot_idle");

        // Sole requester timing out is regranted straight away.
        for (int i = 0; i < 8; i++) step(16'h0008, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b0, "sole_h1");
        step(16'h0008, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b1, "sole_to1");
        for (int i = 0; i < 7; i++) step(16'h0008, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b0, "sole_h2");
        step(16'h0008, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b1, "sole_to2");
        step(16'h0000, 1'b0, 16'h0000, 4'd3, 1'b0, 1'b0, "sole_idle");

        // Pointer wrap 15 -> 0, non-owner churn, DONE together with the hold limit.
        step(16'h8000, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0, "wrap_g15");
        step(16'h8001, 1'b1, 16'h0001, 4'd0, 1'b1, 1'b0, "wrap_g0");
        for (int i = 0; i < 7; i++) begin
            step((i % 2) ? 16'h8001 : 16'h0001, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0, "wrap_hold0");
        end
        step(16'h8001, 1'b1, 16'h8000, 4'd15, 1'b1, 1'b0, "done_at_max");
        step(16'h0000, 1'b1, 16'h0000, 4'd15, 1'b0, 1'b0, "final_idle");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
